// File: rtl/terrain_scroller_if.sv
// -----------------------------------------------------------------------------
// terrain_scroller_if
// Groups the scroll control and the ground-line outputs of one terrain lane.
//   enable_board : scroll enable driven by the game controller (master)
//   line_o       : WIDTH-bit ground bitmap, bit 0 = leftmost column
//   new_col      : value of the column most recently shifted in
//   distance     : saturating count of columns scrolled since reset
// master = game/controller side, slave = terrain_scroller.
// -----------------------------------------------------------------------------
interface terrain_scroller_if #(
  parameter int WIDTH = 640
);
  logic             enable_board;
  logic [WIDTH-1:0] line_o;
  logic             new_col;
  logic [15:0]      distance;

  modport master (
    output enable_board,
    input  line_o,
    input  new_col,
    input  distance
  );

  modport slave (
    input  enable_board,
    output line_o,
    output new_col,
    output distance
  );
endinterface

// File: rtl/terrain_scroller.sv
// -----------------------------------------------------------------------------
// terrain_scroller
// Produces one scrolling ground line. Every enabled tick the line moves one
// column toward x=0 and a new column enters at x=WIDTH-1. New columns come
// from an alternating solid-segment / gap generator whose run lengths are
// drawn from a seeded 16-bit Galois LFSR.
// Ports:
//   clk   : game tick clock
//   reset : asynchronous, active-high reset
//   bus   : terrain_scroller_if slave (enable_board in; line_o, new_col,
//           distance out, all registered)
// -----------------------------------------------------------------------------
module terrain_scroller #(
  parameter int          WIDTH    = 640,
  parameter logic [15:0] SEED     = 16'h0001,
  parameter int          INIT_SEG = 64,
  parameter int          MIN_SEG  = 24,
  parameter int          SEG_SPAN = 32,
  parameter int          MIN_GAP  = 8,
  parameter int          GAP_SPAN = 16
) (
  input  logic              clk,
  input  logic              reset,
  terrain_scroller_if.slave bus
);

  // A zero seed would lock the LFSR, so it is swapped for a known-good value.
  localparam logic [15:0] LP_SEED     = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LP_TAPS     = 16'hB400;
  localparam logic [7:0]  LP_INIT     = 8'(INIT_SEG);
  localparam logic [7:0]  LP_MIN_SEG  = 8'(MIN_SEG);
  localparam logic [7:0]  LP_MIN_GAP  = 8'(MIN_GAP);
  localparam logic [7:0]  LP_SEG_MASK = 8'(SEG_SPAN - 1);
  localparam logic [7:0]  LP_GAP_MASK = 8'(GAP_SPAN - 1);

  // Parameter legality: every run must fit the 8-bit counter and be non-empty.
  if (INIT_SEG < 1 || INIT_SEG > 255) begin : g_bad_init_seg
    $error("terrain_scroller: INIT_SEG must be within 1..255");
  end
  if (MIN_SEG < 1 || SEG_SPAN < 1 || (MIN_SEG + SEG_SPAN - 1) > 255) begin : g_bad_seg
    $error("terrain_scroller: need MIN_SEG>=1, SEG_SPAN>=1, MIN_SEG+SEG_SPAN-1<=255");
  end
  if (MIN_GAP < 1 || GAP_SPAN < 1 || (MIN_GAP + GAP_SPAN - 1) > 255) begin : g_bad_gap
    $error("terrain_scroller: need MIN_GAP>=1, GAP_SPAN>=1, MIN_GAP+GAP_SPAN-1<=255");
  end
  if ((SEG_SPAN & (SEG_SPAN - 1)) != 0) begin : g_bad_seg_span
    $error("terrain_scroller: SEG_SPAN must be a power of two");
  end
  if ((GAP_SPAN & (GAP_SPAN - 1)) != 0) begin : g_bad_gap_span
    $error("terrain_scroller: GAP_SPAN must be a power of two");
  end

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_SEG = 1'b1
  } state_t;

  // One Galois right-shift step; the tap mask folds in when bit 0 shifts out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? LP_TAPS : 16'h0000);
  endfunction

  state_t           r_state;
  logic [7:0]       r_remain;
  logic [15:0]      r_lfsr;
  logic [WIDTH-1:0] r_line;
  logic             r_new_col;
  logic [15:0]      r_distance;

  logic             w_col;
  logic [7:0]       w_next_len;

  // Column value for this tick and the length of the run that follows it.
  always_comb begin
    w_col      = 1'b1;
    w_next_len = LP_MIN_SEG;
    case (r_state)
      ST_SEG: begin
        w_col      = 1'b1;
        // Leaving a segment: the next run is a gap.
        w_next_len = LP_MIN_GAP + (r_lfsr[7:0] & LP_GAP_MASK);
      end
      ST_GAP: begin
        w_col      = 1'b0;
        w_next_len = LP_MIN_SEG + (r_lfsr[7:0] & LP_SEG_MASK);
      end
      default: begin
        w_col      = 1'b1;
        w_next_len = LP_MIN_SEG;
      end
    endcase
  end

  // Run-length FSM, LFSR, line shifter and distance counter; all hold when
  // the board is not enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_SEG;
      r_remain   <= LP_INIT;
      r_lfsr     <= LP_SEED;
      r_line     <= {WIDTH{1'b1}};
      r_new_col  <= 1'b1;
      r_distance <= 16'h0000;
    end else if (bus.enable_board) begin
      r_line    <= {w_col, r_line[WIDTH-1:1]};
      r_new_col <= w_col;
      if (r_distance != 16'hFFFF) begin
        r_distance <= r_distance + 16'h0001;
      end
      // The last column of a run switches the run type and draws its length.
      if (r_remain == 8'd1) begin
        case (r_state)
          ST_SEG:  r_state <= ST_GAP;
          ST_GAP:  r_state <= ST_SEG;
          default: r_state <= ST_SEG;
        endcase
        r_remain <= w_next_len;
        r_lfsr   <= lfsr_step(r_lfsr);
      end else begin
        r_remain <= r_remain - 8'd1;
      end
    end
  end

  assign bus.line_o   = r_line;
  assign bus.new_col  = r_new_col;
  assign bus.distance = r_distance;

endmodule

// File: tb/tb_terrain_scroller.sv
// -----------------------------------------------------------------------------
// tb_terrain_scroller
// Drives two terrain_scroller instances: dut_a with default parameters and
// SEED=16'h0004 (randomized pauses/run checks), dut_b with short fixed runs
// for the deterministic pattern. The reference model generates whole runs
// from the LFSR rule and keeps a history of every emitted column.
// -----------------------------------------------------------------------------
module tb_terrain_scroller;

  localparam int W = 640;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state for dut_a.
  bit   m_val;
  int   m_left;
  int   m_lfsr;
  int   m_n;
  bit   hist[$];

  terrain_scroller_if #(.WIDTH(W)) bus_a ();
  terrain_scroller_if #(.WIDTH(W)) bus_b ();

  terrain_scroller #(
    .WIDTH(W), .SEED(16'h0004), .INIT_SEG(64), .MIN_SEG(24),
    .SEG_SPAN(32), .MIN_GAP(8), .GAP_SPAN(16)
  ) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a)
  );

  terrain_scroller #(
    .WIDTH(W), .SEED(16'h0001), .INIT_SEG(2), .MIN_SEG(4),
    .SEG_SPAN(1), .MIN_GAP(3), .GAP_SPAN(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_adv(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 32'h0000B400 : 32'h00000000);
  endfunction

  task automatic model_reset();
    m_val  = 1'b1;
    m_left = 64;
    m_lfsr = 32'h00000004;
    m_n    = 0;
    hist.delete();
  endtask

  // Produce the next column: start a new run (opposite type) when the current
  // one is used up, with length drawn from the LFSR, which then advances.
  task automatic model_next(output bit col);
    if (m_left == 0) begin
      m_val = !m_val;
      if (m_val) m_left = 24 + (m_lfsr % 32);
      else       m_left = 8 + (m_lfsr % 16);
      m_lfsr = lfsr_adv(m_lfsr);
    end
    col = m_val;
    m_left--;
  endtask

  function automatic logic [W-1:0] exp_line();
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) begin
      int idx;
      idx  = m_n - W + k;
      v[k] = (idx < 0) ? 1'b1 : hist[idx];
    end
    return v;
  endfunction

  function automatic logic [15:0] exp_dist();
    return (m_n > 65535) ? 16'hFFFF : 16'(m_n);
  endfunction

  // One enabled clock on dut_a, advancing the model alongside.
  task automatic step_a(output bit col);
    model_next(col);
    hist.push_back(col);
    m_n++;
    bus_a.enable_board = 1'b1;
    @(posedge clk);
    #1;
    bus_a.enable_board = 1'b0;
  endtask

  task automatic test_reset();
    bus_a.enable_board = 1'b0;
    bus_b.enable_board = 1'b0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    n_checks++;
    if (bus_a.line_o !== {W{1'b1}}) begin
      n_errors++; $display("FAIL reset_line: got %h exp all ones", bus_a.line_o);
    end
    n_checks++;
    if (bus_a.new_col !== 1'b1 || bus_b.new_col !== 1'b1) begin
      n_errors++; $display("FAIL reset_new_col: got a=%b b=%b exp 1", bus_a.new_col, bus_b.new_col);
    end
    n_checks++;
    if (bus_a.distance !== 16'h0000 || bus_b.distance !== 16'h0000) begin
      n_errors++; $display("FAIL reset_distance: got a=%h b=%h exp 0", bus_a.distance, bus_b.distance);
    end
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_a.line_o !== {W{1'b1}} || bus_a.new_col !== 1'b1 || bus_a.distance !== 16'h0000) begin
        n_errors++;
        $display("FAIL idle_hold: cycle %0d new_col=%b distance=%h exp 1/0000, line all ones", i, bus_a.new_col, bus_a.distance);
      end
      n_checks++;
      if (bus_b.line_o !== {W{1'b1}} || bus_b.distance !== 16'h0000) begin
        n_errors++; $display("FAIL idle_hold_b: cycle %0d distance=%h exp 0000", i, bus_b.distance);
      end
    end
  endtask

  task automatic test_deterministic();
    logic [13:0] seq;
    seq = 14'b11000111100011;  // bit i = column emitted on enabled clk i
    for (int i = 0; i < 14; i++) begin
      bus_b.enable_board = 1'b1;
      @(posedge clk);
      #1;
      bus_b.enable_board = 1'b0;
      n_checks++;
      if (bus_b.new_col !== seq[i]) begin
        n_errors++; $display("FAIL det_new_col: clk %0d got %b exp %b", i, bus_b.new_col, seq[i]);
      end
      n_checks++;
      if (bus_b.distance !== 16'(i + 1)) begin
        n_errors++; $display("FAIL det_distance: clk %0d got %0d exp %0d", i, bus_b.distance, i + 1);
      end
    end
    n_checks++;
    if (bus_b.line_o[W-1:W-14] !== seq) begin
      n_errors++; $display("FAIL det_line_top: got %b exp %b", bus_b.line_o[W-1:W-14], seq);
    end
    n_checks++;
    if (bus_b.line_o[W-15:0] !== {(W-14){1'b1}}) begin
      n_errors++; $display("FAIL det_line_rest: reset fill disturbed below bit %0d", W-14);
    end
  endtask

  task automatic test_shift_integrity();
    bit col;
    bit first_col;
    for (int i = 0; i < W; i++) begin
      step_a(col);
      if (i == 0) first_col = col;
      n_checks++;
      if (bus_a.new_col !== col || bus_a.distance !== exp_dist()) begin
        n_errors++;
        $display("FAIL shift_outputs: clk %0d new_col=%b exp %b distance=%0d exp %0d", i, bus_a.new_col, col, bus_a.distance, exp_dist());
      end
      n_checks++;
      if (bus_a.line_o !== exp_line()) begin
        n_errors++; $display("FAIL shift_line: clk %0d line_o differs from model, bit0=%b", i, bus_a.line_o[0]);
      end
      if (i < W - 1) begin
        n_checks++;
        if (bus_a.line_o[0] !== 1'b1) begin
          n_errors++; $display("FAIL shift_fill: clk %0d line_o[0]=%b exp 1", i, bus_a.line_o[0]);
        end
      end
    end
    n_checks++;
    if (bus_a.line_o[0] !== first_col) begin
      n_errors++; $display("FAIL shift_arrival: line_o[0]=%b exp %b", bus_a.line_o[0], first_col);
    end
  endtask

  task automatic test_random_runs();
    bit col;
    bit have_run = 1'b0;
    bit run_val = 1'b0;
    int run_len = 0;
    bit seen_seg = 1'b0;
    bit seen_gap = 1'b0;
    int runs_checked = 0;
    while (m_n < 20000) begin
      step_a(col);
      n_checks++;
      if (bus_a.new_col !== col || bus_a.distance !== exp_dist()) begin
        n_errors++;
        $display("FAIL rand_outputs: n=%0d new_col=%b exp %b distance=%0d exp %0d", m_n, bus_a.new_col, col, bus_a.distance, exp_dist());
      end
      if (m_n % 50 == 0) begin
        n_checks++;
        if (bus_a.line_o !== exp_line()) begin
          n_errors++; $display("FAIL rand_line: n=%0d line_o differs from model", m_n);
        end
      end
      // Measure runs on the observed output; the first of each kind is partial.
      if (have_run && bus_a.new_col == run_val) begin
        run_len++;
      end else begin
        if (have_run) begin
          if (run_val) begin
            if (seen_seg) begin
              runs_checked++;
              n_checks++;
              if (run_len < 24 || run_len > 55) begin
                n_errors++; $display("FAIL seg_run_len: got %0d exp 24..55", run_len);
              end
            end
            seen_seg = 1'b1;
          end else begin
            if (seen_gap) begin
              runs_checked++;
              n_checks++;
              if (run_len < 8 || run_len > 23) begin
                n_errors++; $display("FAIL gap_run_len: got %0d exp 8..23", run_len);
              end
            end
            seen_gap = 1'b1;
          end
        end
        have_run = 1'b1;
        run_val  = bus_a.new_col;
        run_len  = 1;
      end
    end
    n_checks++;
    if (runs_checked < 100) begin
      n_errors++; $display("FAIL run_count: got %0d runs exp at least 100", runs_checked);
    end
  endtask

  task automatic test_pause_resume();
    bit col;
    int guard = 0;
    int rem;
    int hold;
    logic [W-1:0] line_s;
    logic         nc_s;
    logic [15:0]  dist_s;
    hold = 2 + int'($urandom_range(0, 3));
    // Scroll until the model sits inside a gap with columns still to come.
    while (!(m_val == 1'b0 && m_left >= hold) && guard < 200) begin
      step_a(col);
      guard++;
    end
    n_checks++;
    if (guard >= 200) begin
      n_errors++; $display("FAIL pause_setup: no mid-gap point within 200 clks, got %0d exp <200", guard);
    end
    rem    = m_left;
    line_s = bus_a.line_o;
    nc_s   = bus_a.new_col;
    dist_s = bus_a.distance;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_a.line_o !== line_s || bus_a.new_col !== nc_s || bus_a.distance !== dist_s) begin
        n_errors++;
        $display("FAIL pause_hold: clk %0d new_col=%b exp %b distance=%0d exp %0d", i, bus_a.new_col, nc_s, bus_a.distance, dist_s);
      end
    end
    for (int i = 0; i < rem; i++) begin
      step_a(col);
      n_checks++;
      if (bus_a.new_col !== 1'b0 || bus_a.distance !== exp_dist()) begin
        n_errors++;
        $display("FAIL resume_gap: col %0d of %0d new_col=%b exp 0 distance=%0d exp %0d", i, rem, bus_a.new_col, bus_a.distance, exp_dist());
      end
    end
    step_a(col);
    n_checks++;
    if (bus_a.new_col !== 1'b1) begin
      n_errors++; $display("FAIL resume_gap_end: new_col=%b exp 1 after %0d gap cols", bus_a.new_col, rem);
    end
    n_checks++;
    if (bus_a.line_o !== exp_line()) begin
      n_errors++; $display("FAIL resume_line: line_o differs from model");
    end
  endtask

  task automatic test_saturation();
    bit col;
    while (m_n < 65534) begin
      step_a(col);
      n_checks++;
      if (bus_a.new_col !== col || bus_a.distance !== exp_dist()) begin
        n_errors++;
        $display("FAIL sat_run: n=%0d new_col=%b exp %b distance=%0d exp %0d", m_n, bus_a.new_col, col, bus_a.distance, exp_dist());
      end
      if (m_n % 1000 == 0) begin
        n_checks++;
        if (bus_a.line_o !== exp_line()) begin
          n_errors++; $display("FAIL sat_run_line: n=%0d line_o differs from model", m_n);
        end
      end
    end
    n_checks++;
    if (bus_a.distance !== 16'hFFFE) begin
      n_errors++; $display("FAIL sat_pre: distance=%h exp FFFE", bus_a.distance);
    end
    for (int i = 0; i < 3; i++) begin
      step_a(col);
      n_checks++;
      if (bus_a.distance !== 16'hFFFF) begin
        n_errors++; $display("FAIL sat_hold: clk %0d distance=%h exp FFFF", i, bus_a.distance);
      end
      n_checks++;
      if (bus_a.line_o !== exp_line() || bus_a.new_col !== col) begin
        n_errors++; $display("FAIL sat_shift: clk %0d new_col=%b exp %b or line_o differs", i, bus_a.new_col, col);
      end
    end
  endtask

  task automatic test_async_reset();
    bit col;
    bus_a.enable_board = 1'b0;
    #3;
    rst_a = 1'b1;
    #1;
    n_checks++;
    if (bus_a.line_o !== {W{1'b1}} || bus_a.new_col !== 1'b1 || bus_a.distance !== 16'h0000) begin
      n_errors++;
      $display("FAIL async_reset: new_col=%b distance=%h exp 1/0000, line all ones", bus_a.new_col, bus_a.distance);
    end
    #2;
    rst_a = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step_a(col);
      n_checks++;
      if (bus_a.new_col !== col || bus_a.distance !== exp_dist() || bus_a.line_o !== exp_line()) begin
        n_errors++;
        $display("FAIL post_reset: clk %0d new_col=%b exp %b distance=%0d exp %0d", i, bus_a.new_col, col, bus_a.distance, exp_dist());
      end
    end
  endtask

  initial begin
    test_reset();
    test_deterministic();
    test_shift_integrity();
    test_random_runs();
    test_pause_resume();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
